// File: rtl/regfile_pkg.sv
// Shared sizing defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_REGS = 32;

  function automatic int addrWidth(input int numRegs);
    return (numRegs <= 2) ? 1 : $clog2(numRegs);
  endfunction

  localparam int DEF_AW = addrWidth(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]     reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for in-flight writes plus a running busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = DEF_NUM_REGS - 1,
  localparam int AW      = addrWidth(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic [AW-1:0]       wrAddr,
  input  logic                issEn,
  input  logic [AW-1:0]       issAddr,
  output logic [NUM_REGS-1:0] busy,
  output logic [AW:0]         busyCnt
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

  logic wrHit;
  logic issHit;
  logic setEv;
  logic clrEv;

  assign wrHit  = wrEn && (wrAddr != ZIDX);
  assign issHit = issEn && (issAddr != ZIDX);

  // Count only real transitions; a same-index issue overrides the write's clear.
  assign setEv = issHit && !busy[issAddr];
  assign clrEv = wrHit && busy[wrAddr] && !(issHit && (issAddr == wrAddr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      if (wrHit) busy[wrAddr] <= 1'b0;
      if (issHit) busy[issAddr] <= 1'b1;
      busyCnt <= busyCnt + (AW+1)'(setEv) - (AW+1)'(clrEv);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register,
// optional write->read bypass and a busy scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = addrWidth(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [AW-1:0]              iss_addr,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [AW:0]                busy_cnt,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);
  localparam bit            BYP  = (BYPASS != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wrHit;

  assign wrHit = wr_en && (wr_addr != ZIDX);

  // The zero register is never written, so its storage stays at its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wrHit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (wr_en),
    .wrAddr  (wr_addr),
    .issEn   (iss_en),
    .issAddr (iss_addr),
    .busy    (busy),
    .busyCnt (busy_cnt)
  );

  for (genvar r = 0; r < NUM_REGS; r++) begin : gRegOut
    assign reg_out[r*DATA_W +: DATA_W] = regs[r];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRead
    logic [AW-1:0] addr;
    logic          fwd;

    assign addr = rd_addr[p*AW +: AW];
    assign fwd  = BYP && wrHit && (wr_addr == addr);
    assign rd_data[p*DATA_W +: DATA_W] = (addr == ZIDX) ? '0 :
                                         fwd            ? wr_data : regs[addr];
    assign rd_busy[p] = busy[addr] && !fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: bypass and non-bypass 32x64 files plus a 16x32 four-port file.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          we, ie;
  logic [4:0]    wa, ia;
  logic [63:0]   wd;
  logic [9:0]    ra;
  logic [127:0]  rd0, rd1;
  logic [1:0]    bz0, bz1;
  logic [5:0]    cnt0, cnt1;
  logic [2047:0] ro0, ro1;

  logic          pWe, pIe;
  logic [3:0]    pWa, pIa;
  logic [31:0]   pWd;
  logic [15:0]   pRa;
  logic [127:0]  pRd;
  logic [3:0]    pBz;
  logic [4:0]    pCnt;
  logic [511:0]  pRo;

  regfile_mp #(.BYPASS(1)) dutByp (
    .clk(clk), .rst(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .iss_en(ie), .iss_addr(ia), .rd_addr(ra), .rd_data(rd0),
    .rd_busy(bz0), .busy_cnt(cnt0), .reg_out(ro0));

  regfile_mp #(.BYPASS(0)) dutNoByp (
    .clk(clk), .rst(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .iss_en(ie), .iss_addr(ia), .rd_addr(ra), .rd_data(rd1),
    .rd_busy(bz1), .busy_cnt(cnt1), .reg_out(ro1));

  regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .ZERO_REG(15), .BYPASS(1)) dutSmall (
    .clk(clk), .rst(rst), .wr_en(pWe), .wr_addr(pWa), .wr_data(pWd),
    .iss_en(pIe), .iss_addr(pIa), .rd_addr(pRa), .rd_data(pRd),
    .rd_busy(pBz), .busy_cnt(pCnt), .reg_out(pRo));

  typedef struct packed {
    logic [127:0]  rd0;
    logic [127:0]  rd1;
    logic [1:0]    bz0;
    logic [1:0]    bz1;
    logic [5:0]    cnt;
    logic [2047:0] ro;
    logic [127:0]  prd;
    logic [3:0]    pbz;
    logic [4:0]    pcnt;
    logic [511:0]  pro;
  } exp_t;

  exp_t q[$];
  int nTests = 0;
  int nFail  = 0;

  // Reference model: plain arrays of register values and busy flags.
  logic [63:0] mReg [32];
  bit          mBusy[32];
  logic [31:0] pReg [16];
  bit          pBusy[16];

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin mReg[i] = '0; mBusy[i] = 0; end
    for (int i = 0; i < 16; i++) begin pReg[i] = '0; pBusy[i] = 0; end
  endtask

  // Apply what the DUT saw at this edge: write clears busy, then issue sets it.
  task automatic commit();
    if (rst) begin
      if (we && wa != 5'd31) begin mReg[wa] = wd; mBusy[wa] = 0; end
      if (ie && ia != 5'd31) mBusy[ia] = 1;
      if (pWe && pWa != 4'd15) begin pReg[pWa] = pWd; pBusy[pWa] = 0; end
      if (pIe && pIa != 4'd15) pBusy[pIa] = 1;
    end
  endtask

  task automatic pushExp();
    exp_t e;
    int   n;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      bit hit;
      a   = ra[p*5 +: 5];
      hit = we && (wa == a) && (wa != 5'd31);
      e.rd0[p*64 +: 64] = (a == 5'd31) ? 64'd0 : (hit ? wd : mReg[a]);
      e.rd1[p*64 +: 64] = (a == 5'd31) ? 64'd0 : mReg[a];
      e.bz0[p] = (a != 5'd31) && mBusy[a] && !hit;
      e.bz1[p] = (a != 5'd31) && mBusy[a];
    end
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(mBusy[i]);
      e.ro[i*64 +: 64] = (i == 31) ? 64'd0 : mReg[i];
    end
    e.cnt = 6'(n);
    for (int p = 0; p < 4; p++) begin
      logic [3:0] a;
      bit hit;
      a   = pRa[p*4 +: 4];
      hit = pWe && (pWa == a) && (pWa != 4'd15);
      e.prd[p*32 +: 32] = (a == 4'd15) ? 32'd0 : (hit ? pWd : pReg[a]);
      e.pbz[p] = (a != 4'd15) && pBusy[a] && !hit;
    end
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += int'(pBusy[i]);
      e.pro[i*32 +: 32] = (i == 15) ? 32'd0 : pReg[i];
    end
    e.pcnt = 5'(n);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic chkRegs(input string name, input logic [2047:0] got, input logic [2047:0] exp,
                         input int n, input int w);
    int bad;
    bad = -1;
    nTests++;
    for (int i = n - 1; i >= 0; i--) begin
      logic [63:0] g, x;
      g = 64'(got >> (i * w));
      x = 64'(exp >> (i * w));
      if (w == 32) begin g[63:32] = '0; x[63:32] = '0; end
      if (g !== x) bad = i;
    end
    if (bad >= 0) begin
      nFail++;
      $display("FAIL %s t=%0t reg[%0d] got=%0h exp=%0h", name, $time, bad,
               64'(got >> (bad * w)) & ((w == 32) ? 64'hFFFF_FFFF : '1),
               64'(exp >> (bad * w)) & ((w == 32) ? 64'hFFFF_FFFF : '1));
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data_byp",   rd0,          e.rd0);
      chk("rd_busy_byp",   128'(bz0),    128'(e.bz0));
      chk("busy_cnt_byp",  128'(cnt0),   128'(e.cnt));
      chkRegs("reg_out_byp", ro0, e.ro, 32, 64);
      chk("rd_data_nobyp", rd1,          e.rd1);
      chk("rd_busy_nobyp", 128'(bz1),    128'(e.bz1));
      chk("busy_cnt_nobyp",128'(cnt1),   128'(e.cnt));
      chkRegs("reg_out_nobyp", ro1, e.ro, 32, 64);
      chk("rd_data_small", pRd,          e.prd);
      chk("rd_busy_small", 128'(pBz),    128'(e.pbz));
      chk("busy_cnt_small",128'(pCnt),   128'(e.pcnt));
      chkRegs("reg_out_small", 2048'(pRo), 2048'(e.pro), 16, 32);
    end
  end

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drv(input logic w, input logic [4:0] a, input logic [63:0] d,
                     input logic i, input logic [4:0] ai, input logic [9:0] r);
    we = w; wa = a; wd = d; ie = i; ia = ai; ra = r;
  endtask

  task automatic pdrv(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic i, input logic [3:0] ai, input logic [15:0] r);
    pWe = w; pWa = a; pWd = d; pIe = i; pIa = ai; pRa = r;
  endtask

  function automatic logic [4:0] pickMain();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'd31;
    if (r < 6)  return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [3:0] pickSmall();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 4'd15;
    if (r < 6)  return 4'($urandom_range(0, 5));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    pdrv(0, 0, 0, 0, 0, 0);
    modelReset();

    // Reset state, then release.
    tick(); pushExp();
    tick(); rst = 1'b1; pushExp();

    // Same-cycle bypass versus old value, then both see the written value.
    tick(); drv(1, 5, 64'h1234, 0, 0, {5'd0, 5'd5}); pushExp();
    tick(); drv(0, 0, 0, 0, 0, {5'd0, 5'd5}); pushExp();

    // Zero register ignores writes and issues.
    tick(); drv(1, 31, 64'hDEAD_BEEF, 1, 31, {5'd31, 5'd31}); pushExp();
    tick(); drv(0, 0, 0, 0, 0, {5'd31, 5'd31}); pushExp();

    // Scoreboard set and clear.
    tick(); drv(0, 0, 0, 1, 3, {5'd7, 5'd3}); pushExp();
    tick(); drv(0, 0, 0, 1, 7, {5'd7, 5'd3}); pushExp();
    tick(); drv(0, 0, 0, 0, 0, {5'd7, 5'd3}); pushExp();
    tick(); drv(1, 3, 64'hAAAA, 0, 0, {5'd7, 5'd3}); pushExp();
    tick(); drv(0, 0, 0, 0, 0, {5'd7, 5'd3}); pushExp();

    // Write and issue to the same busy register on one edge.
    tick(); drv(0, 0, 0, 1, 9, {5'd9, 5'd9}); pushExp();
    tick(); drv(1, 9, 64'h9999, 1, 9, {5'd9, 5'd9}); pushExp();
    tick(); drv(0, 0, 0, 0, 0, {5'd9, 5'd9}); pushExp();

    // Four-port narrow file: fill x2..x5, read them, then aliased reads.
    for (int i = 2; i <= 5; i++) begin
      tick(); drv(0, 0, 0, 0, 0, 0);
      pdrv(1, 4'(i), 32'hC0DE_0000 + 32'(i), 0, 0, {4'd15, 4'd15, 4'd15, 4'(i)});
      pushExp();
    end
    tick(); pdrv(0, 0, 0, 0, 0, {4'd5, 4'd4, 4'd3, 4'd2}); pushExp();
    tick(); pdrv(0, 0, 0, 0, 0, {4'd3, 4'd5, 4'd3, 4'd3}); pushExp();
    tick(); pdrv(1, 15, 32'hFFFF_FFFF, 1, 15, {4'd15, 4'd15, 4'd2, 4'd15}); pushExp();

    // Randomized traffic on all three instances.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] a, r0, r1;
      logic [3:0] b;
      logic [15:0] pr;
      tick();
      a  = pickMain();
      r0 = ($urandom_range(0, 2) == 0) ? a : pickMain();
      r1 = ($urandom_range(0, 2) == 0) ? a : pickMain();
      drv(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? a : pickMain(), {r1, r0});
      b = pickSmall();
      for (int p = 0; p < 4; p++)
        pr[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? b : pickSmall();
      pdrv(1'($urandom_range(0, 1)), b, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? b : pickSmall(), pr);
      pushExp();
    end

    // Asynchronous reset in the middle of a cycle with a write/issue pending.
    tick(); drv(1, 4, 64'h4444, 1, 6, {5'd6, 5'd4});
    pdrv(1, 3, 32'h3333, 1, 2, {4'd3, 4'd2, 4'd1, 4'd0});
    #1;
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, {5'd6, 5'd4});
    pdrv(0, 0, 0, 0, 0, {4'd3, 4'd2, 4'd1, 4'd0});
    modelReset();
    pushExp();
    tick(); pushExp();
    tick(); rst = 1'b1; pushExp();
    tick(); pushExp();

    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL drain got=%0d exp=0 entries left", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
